// File: rtl/prt_dp_pkg.sv
// Shared definitions for the control-message master: FSM states and the
// word positions of a control frame (header, mask, value).
package prt_dp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      MSK,
      DAT,
      WAIT
   } ctl_state_t;

   localparam logic [1:0] POS_HDR = 2'd0;
   localparam logic [1:0] POS_MSK = 2'd1;
   localparam logic [1:0] POS_VAL = 2'd2;

endpackage

// File: rtl/prt_dp_msg_if.sv
// Message ring link: one word per cycle, framed by som/eom, qualified by vld.
interface prt_dp_msg_if #(
   parameter int P_DAT = 16
);
   logic             som;
   logic             eom;
   logic             vld;
   logic [P_DAT-1:0] dat;

   modport src (output som, eom, dat, vld);
   modport snk (input som, eom, dat, vld);
endinterface

// File: rtl/prt_dp_ctl_msg_chk.sv
// Return-frame comparator: follows frames on the ring return and flags a
// match or mismatch when a frame carrying our header completes or breaks.
module prt_dp_ctl_msg_chk
   import prt_dp_pkg::*;
#(
   parameter int P_MSG_DAT = 16,
   parameter int P_MSG_ID  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 som,
   input  logic                 eom,
   input  logic                 vld,
   input  logic [P_MSG_DAT-1:0] dat,
   input  logic [P_MSG_DAT-1:0] msk,
   input  logic [P_MSG_DAT-1:0] val,
   output logic                 match,
   output logic                 mismatch
);

   localparam logic [P_MSG_DAT-1:0] HDR_WORD = P_MSG_DAT'(P_MSG_ID);

   logic [1:0] pos_reg;
   logic       ours_reg;
   logic       diff_reg;
   logic [1:0] wpos;
   logic       tracking;
   logic       wdiff;

   always_comb begin
      wpos     = som ? POS_HDR : pos_reg;
      tracking = som ? (dat == HDR_WORD) : ours_reg;
      wdiff    = ((wpos == POS_MSK) && (dat != msk)) || ((wpos == POS_VAL) && (dat != val));
      match    = 1'b0;
      mismatch = 1'b0;
      if (en && vld && tracking) begin
         if (wpos == POS_VAL) begin
            if (!diff_reg && !wdiff && eom) match = 1'b1;
            else                            mismatch = 1'b1;
         end else if (eom) begin
            mismatch = 1'b1;
         end
      end
   end

   // A som always restarts the frame, discarding whatever was partially seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_reg  <= 2'd0;
         ours_reg <= 1'b0;
         diff_reg <= 1'b0;
      end else if (!en) begin
         pos_reg  <= 2'd0;
         ours_reg <= 1'b0;
         diff_reg <= 1'b0;
      end else if (vld) begin
         if (som) begin
            pos_reg  <= POS_MSK;
            ours_reg <= (dat == HDR_WORD) && !eom;
            diff_reg <= 1'b0;
         end else begin
            if (pos_reg != 2'd3) pos_reg <= pos_reg + 2'd1;
            if (ours_reg) begin
               diff_reg <= diff_reg | wdiff;
               if (eom || (pos_reg == POS_VAL)) ours_reg <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/prt_dp_ctl_msg_mst.sv
// Control-message master: sends a header/mask/value frame on the ring and
// waits for it to come back intact. Optional return timeout: PRT_DP_CTL_MSG_TIMEOUT_EN.
module prt_dp_ctl_msg_mst
   import prt_dp_pkg::*;
#(
   parameter int P_MSG_DAT = 16,
   parameter int P_MSG_ID  = 0,
   parameter int P_TO_CYC  = 1023
) (
   input  logic                 RST_IN,
   input  logic                 CLK_IN,
   prt_dp_msg_if.src            MSG_SRC_IF,
   prt_dp_msg_if.snk            MSG_SNK_IF,
   input  logic                 REQ_IN,
   input  logic [P_MSG_DAT-1:0] REQ_MSK_IN,
   input  logic [P_MSG_DAT-1:0] REQ_DAT_IN,
   output logic                 BUSY_OUT,
   output logic                 DONE_OUT,
   output logic                 ERR_OUT
);

   localparam logic [P_MSG_DAT-1:0] HDR_WORD = P_MSG_DAT'(P_MSG_ID);

   ctl_state_t           state_reg, state_next;
   logic [P_MSG_DAT-1:0] msk_reg;
   logic [P_MSG_DAT-1:0] val_reg;
   logic                 done_reg, done_next;
   logic                 err_reg, err_next;
   logic                 chk_match;
   logic                 chk_mismatch;
   logic                 timeout;
   logic                 src_vld, src_som, src_eom;
   logic [P_MSG_DAT-1:0] src_dat;

`ifdef PRT_DP_CTL_MSG_TIMEOUT_EN
   localparam int TO_W = $clog2(P_TO_CYC + 1);
   logic [TO_W-1:0] to_cnt_reg;

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN)                 to_cnt_reg <= '0;
      else if (state_reg == WAIT) to_cnt_reg <= to_cnt_reg + TO_W'(1);
      else                        to_cnt_reg <= '0;
   end

   assign timeout = (state_reg == WAIT) && (to_cnt_reg == TO_W'(P_TO_CYC - 1));
`else
   assign timeout = 1'b0;
   // Without the timeout P_TO_CYC has no effect.
   if (P_TO_CYC < 1) begin : g_to_unused
   end
`endif

   // Tracking runs from HDR onward because a short ring returns our header
   // while the later words are still going out.
   prt_dp_ctl_msg_chk #(
      .P_MSG_DAT (P_MSG_DAT),
      .P_MSG_ID  (P_MSG_ID)
   ) u_chk (
      .clk      (CLK_IN),
      .rst      (RST_IN),
      .en       (state_reg != IDLE),
      .som      (MSG_SNK_IF.som),
      .eom      (MSG_SNK_IF.eom),
      .vld      (MSG_SNK_IF.vld),
      .dat      (MSG_SNK_IF.dat),
      .msk      (msk_reg),
      .val      (val_reg),
      .match    (chk_match),
      .mismatch (chk_mismatch)
   );

   // Results only count once our value word is on the ring, so a stale
   // frame seen during HDR/MSK cannot cut our own frame short.
   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: if (REQ_IN) state_next = HDR;
         HDR:  state_next = MSK;
         MSK:  state_next = DAT;
         DAT, WAIT: begin
            if (chk_match) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (chk_mismatch || timeout) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else begin
               state_next = WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_reg <= IDLE;
         msk_reg   <= '0;
         val_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         if ((state_reg == IDLE) && REQ_IN) begin
            msk_reg <= REQ_MSK_IN;
            val_reg <= REQ_DAT_IN;
         end
      end
   end

   always_comb begin
      src_vld = 1'b0;
      src_som = 1'b0;
      src_eom = 1'b0;
      src_dat = '0;
      case (state_reg)
         HDR: begin
            src_vld = 1'b1;
            src_som = 1'b1;
            src_dat = HDR_WORD;
         end
         MSK: begin
            src_vld = 1'b1;
            src_dat = msk_reg;
         end
         DAT: begin
            src_vld = 1'b1;
            src_eom = 1'b1;
            src_dat = val_reg;
         end
         default: ;
      endcase
   end

   assign MSG_SRC_IF.vld = src_vld;
   assign MSG_SRC_IF.som = src_som;
   assign MSG_SRC_IF.eom = src_eom;
   assign MSG_SRC_IF.dat = src_dat;
   assign BUSY_OUT       = (state_reg != IDLE);
   assign DONE_OUT       = done_reg;
   assign ERR_OUT        = err_reg;

endmodule

// File: tb/tb_prt_dp_ctl_msg_mst.sv
// Bench for prt_dp_ctl_msg_mst: a frame-level reference model checked every
// cycle, directed ring scenarios and randomized traffic through a delay ring.
module tb_prt_dp_ctl_msg_mst;

   localparam int W  = 16;
   localparam int ID = 0;
`ifdef PRT_DP_CTL_MSG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int TO    = 16;
`else
   localparam bit TO_EN = 1'b0;
   localparam int TO    = 1023;
`endif

   typedef struct packed {
      logic         som;
      logic         eom;
      logic         vld;
      logic [W-1:0] dat;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0;
   logic [W-1:0] req_msk = '0;
   logic [W-1:0] req_dat = '0;
   logic busy, done, err;

   always #5 clk = ~clk;

   prt_dp_msg_if #(.P_DAT(W)) src_if ();
   prt_dp_msg_if #(.P_DAT(W)) snk_if ();

   prt_dp_ctl_msg_mst #(
      .P_MSG_DAT (W),
      .P_MSG_ID  (ID),
      .P_TO_CYC  (TO)
   ) dut (
      .RST_IN     (rst),
      .CLK_IN     (clk),
      .MSG_SRC_IF (src_if),
      .MSG_SNK_IF (snk_if),
      .REQ_IN     (req),
      .REQ_MSK_IN (req_msk),
      .REQ_DAT_IN (req_dat),
      .BUSY_OUT   (busy),
      .DONE_OUT   (done),
      .ERR_OUT    (err)
   );

   // ---------------- ring: delay line, corruption, injection ----------------
   int    ring_d  = 0;       // <0: nothing returns, 0: wire, 1..3: register stages
   int    corrupt = 0;       // 1: value^1, 2: mask^8000, 3: drop eom, 4: early eom
   word_t inj     = '0;
   word_t src_w, snk_w;
   word_t hist [0:2];

   assign src_w = {src_if.som, src_if.eom, src_if.vld, src_if.dat};

   always @(posedge clk) begin
      if (rst) begin
         hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
      end else begin
         hist[0] <= src_w; hist[1] <= hist[0]; hist[2] <= hist[1];
      end
   end

   always_comb begin
      snk_w = '0;
      if (ring_d == 0)     snk_w = src_w;
      else if (ring_d > 0) snk_w = hist[ring_d-1];
      if (snk_w.vld) begin
         case (corrupt)
            1: if (snk_w.eom) snk_w.dat = snk_w.dat ^ 16'h0001;
            2: if (!snk_w.som && !snk_w.eom) snk_w.dat = snk_w.dat ^ 16'h8000;
            3: if (snk_w.eom) snk_w.eom = 1'b0;
            4: if (!snk_w.som && !snk_w.eom) snk_w.eom = 1'b1;
            default: ;
         endcase
      end
      if (inj.vld) snk_w = inj;
   end

   assign snk_if.som = snk_w.som;
   assign snk_if.eom = snk_w.eom;
   assign snk_if.vld = snk_w.vld;
   assign snk_if.dat = snk_w.dat;

   // ---------------- reference model + per-cycle compare ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   word_t        exp_w = '0;
   logic         e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   bit           m_busy = 1'b0;
   logic [W-1:0] m_msk, m_val;
   word_t        tx_q [$];
   logic [W-1:0] rx_q [$];
   int           m_wait = 0;

   // observation log used by the directed checks
   int           done_n, err_n, som_n, vld_n, done_cyc, err_cyc, eom_cyc;
   logic [W-1:0] wlog [$];

   function automatic word_t mk(bit s, bit e, logic [W-1:0] d);
      word_t r;
      r.som = s; r.eom = e; r.vld = 1'b1; r.dat = d;
      return r;
   endfunction

   always @(negedge clk) begin
      logic [W+5:0] act, want;
      bit decided, ok;
      if (rst) begin
         exp_w = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end
      act  = {src_if.vld, src_if.som, src_if.eom, busy, done, err, src_if.dat};
      want = {exp_w.vld, exp_w.som, exp_w.eom, e_busy, e_done, e_err, exp_w.dat};
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL cycle=%0d outputs got vld%b som%b eom%b dat=%h busy%b done%b err%b want vld%b som%b eom%b dat=%h busy%b done%b err%b",
                  cyc, act[W+5], act[W+4], act[W+3], act[W-1:0], act[W+2], act[W+1], act[W],
                  want[W+5], want[W+4], want[W+3], want[W-1:0], want[W+2], want[W+1], want[W]);
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if (err)  begin err_n++;  err_cyc  = cyc; end
      if (src_if.vld) begin vld_n++; wlog.push_back(src_if.dat); end
      if (src_if.som) som_n++;
      if (src_if.eom) eom_cyc = cyc;

      if (rst) begin
         m_busy = 1'b0; tx_q.delete(); rx_q.delete(); m_wait = 0;
      end else begin
         decided = 1'b0; ok = 1'b0;
         if (m_busy) begin
            if (snk_if.vld) begin
               if (snk_if.som) begin
                  rx_q.delete(); rx_q.push_back(snk_if.dat);
               end else if (rx_q.size() > 0) begin
                  rx_q.push_back(snk_if.dat);
               end
               if (rx_q.size() > 0 && rx_q[0] == W'(ID) && (rx_q.size() == 3 || snk_if.eom)) begin
                  ok = (rx_q.size() == 3) && snk_if.eom && rx_q[1] == m_msk && rx_q[2] == m_val;
                  decided = (tx_q.size() == 0);   // our value word is already out
                  rx_q.delete();
               end
            end
            if (TO_EN && !decided && !exp_w.vld) begin
               m_wait++;
               if (m_wait == TO) begin decided = 1'b1; ok = 1'b0; end
            end
            if (decided) begin m_busy = 1'b0; m_wait = 0; end
         end else begin
            rx_q.delete();
            if (req) begin
               m_busy = 1'b1; m_msk = req_msk; m_val = req_dat; m_wait = 0;
               tx_q.push_back(mk(1'b1, 1'b0, W'(ID)));
               tx_q.push_back(mk(1'b0, 1'b0, req_msk));
               tx_q.push_back(mk(1'b0, 1'b1, req_dat));
            end
         end
         e_done = decided && ok;
         e_err  = decided && !ok;
         exp_w  = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
         e_busy = m_busy;
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(string nm, int got, int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
      end
   endtask

   task automatic clear_log();
      done_n = 0; err_n = 0; som_n = 0; vld_n = 0;
      done_cyc = -1; err_cyc = -1; eom_cyc = -1;
      wlog.delete();
   endtask

   task automatic do_req(input logic [W-1:0] m, input logic [W-1:0] d, output int r);
      req = 1'b1; req_msk = m; req_dat = d; r = cyc;
      tick();
      req = 1'b0;
   endtask

   task automatic wait_idle(int lim);
      int n = 0;
      while (busy && n < lim) begin tick(); n++; end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL wait_idle got=busy want=idle within %0d cycles", lim);
         rst = 1'b1; tick(); rst = 1'b0;
      end
   endtask

   task automatic inject(bit s, bit e, logic [W-1:0] d);
      inj = mk(s, e, d);
      tick();
   endtask

   initial begin
      int r;
      int extra;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_busy", busy, 0);
      check("reset_vld", src_if.vld, 0);
      check("reset_done_err", {done, err}, 0);

      // loopback, good frame
      clear_log(); ring_d = 0; corrupt = 0;
      do_req(16'h001F, 16'h0015, r);
      wait_idle(30); repeat (2) tick();
      check("lb_words", wlog.size(), 3);
      if (wlog.size() == 3) begin
         check("lb_w0", wlog[0], 16'h0000);
         check("lb_w1", wlog[1], 16'h001F);
         check("lb_w2", wlog[2], 16'h0015);
      end
      check("lb_som", som_n, 1);
      check("lb_eom_cyc", eom_cyc - r, 3);
      check("lb_done_lat", done_cyc - r, 4);
      check("lb_err", err_n, 0);
      $display("txn loopback done_lat=%0d", done_cyc - r);

      // loopback, word2 corrupted to 0x0014
      clear_log(); corrupt = 1;
      do_req(16'h001F, 16'h0015, r);
      wait_idle(30); repeat (2) tick();
      check("corrupt_err", err_n, 1);
      check("corrupt_done", done_n, 0);
      check("corrupt_err_lat", err_cyc - r, 4);
      $display("txn corrupt err_lat=%0d", err_cyc - r);

      // second request while busy is dropped
      clear_log(); corrupt = 0;
      do_req(16'h00A5, 16'h005A, r);
      tick();
      req = 1'b1; req_msk = 16'hFFFF; req_dat = 16'h1234;
      tick(); req = 1'b0;
      wait_idle(30); repeat (4) tick();
      check("busy_req_frames", som_n, 1);
      check("busy_req_done", done_n, 1);
      $display("txn busy_req frames=%0d", som_n);

      // foreign frame returns first, then ours
      clear_log(); ring_d = 3;
      do_req(16'h0F0F, 16'h0101, r);
      inject(1'b1, 1'b0, 16'h0003);
      inject(1'b0, 1'b0, 16'hAAAA);
      inject(1'b0, 1'b1, 16'h5555);
      inj = '0;
      wait_idle(30); repeat (2) tick();
      check("foreign_done_lat", done_cyc - r, 7);
      check("foreign_err", err_n, 0);
      $display("txn foreign done_lat=%0d", done_cyc - r);

      // partial frame with our header is discarded by the next som
      clear_log();
      do_req(16'h0123, 16'h0456, r);
      inject(1'b1, 1'b0, 16'h0000);
      inject(1'b0, 1'b0, 16'h0122);
      inj = '0;
      wait_idle(30); repeat (2) tick();
      check("restart_done_lat", done_cyc - r, 7);
      check("restart_err", err_n, 0);
      $display("txn restart done_lat=%0d", done_cyc - r);

      // reset during the mask word
      clear_log(); ring_d = 0;
      do_req(16'h0033, 16'h0044, r);
      tick();
      rst = 1'b1;
      #2;
      check("rst_mid_vld", src_if.vld, 0);
      check("rst_mid_busy", busy, 0);
      tick(); rst = 1'b0;
      clear_log();
      repeat (6) tick();
      check("rst_no_words", vld_n, 0);
      check("rst_no_pulse", done_n + err_n, 0);
      $display("txn reset_mid words_after=%0d", vld_n);

`ifdef PRT_DP_CTL_MSG_TIMEOUT_EN
      // nothing returns: timeout 16 cycles after entering WAIT
      clear_log(); ring_d = -1;
      do_req(16'h0001, 16'h0002, r);
      wait_idle(60); repeat (2) tick();
      check("timeout_lat", err_cyc - (r + 4), 16);
      check("timeout_done", done_n, 0);
      $display("txn timeout err_after_wait=%0d", err_cyc - (r + 4));
`endif

      // randomized traffic through the delay ring
      for (int i = 0; i < 80; i++) begin
         clear_log();
         ring_d  = $urandom_range(0, 3);
         corrupt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         if (corrupt == 4 && ring_d == 0) ring_d = 1;
         extra = $urandom_range(0, 1);
         do_req(W'($urandom), W'($urandom), r);
         if (extra != 0) begin
            req = 1'b1; req_msk = W'($urandom); req_dat = W'($urandom);
            tick(); req = 1'b0;
         end
         wait_idle(40);
         $display("txn %0d msk=%h dat=%h ring=%0d corrupt=%0d done=%0d err=%0d",
                  i, req_msk, req_dat, ring_d, corrupt, done_n, err_n);
         repeat ($urandom_range(0, 2)) tick();
      end
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
